// File: rtl/tank_level_ctrl_if.sv
// Signal bundle between the tank level controller and its probes, fault inputs and valve/status consumers.
interface tank_level_ctrl_if #(
   parameter int N_CH = 4
);
   logic                en;
   logic [3*N_CH-1:0]   probe;
   logic [N_CH-1:0]     ext_fault;
   logic [N_CH-1:0]     fault_clr;
   logic [N_CH-1:0]     valve;
   logic [2*N_CH-1:0]   level;
   logic [N_CH-1:0]     fault;
   logic [2*N_CH-1:0]   fault_code;
   logic                any_fault;

   modport master (
      output en, probe, ext_fault, fault_clr,
      input  valve, level, fault, fault_code, any_fault
   );

   modport slave (
      input  en, probe, ext_fault, fault_clr,
      output valve, level, fault, fault_code, any_fault
   );
endinterface

// File: rtl/tank_level_ctrl.sv
// Per-channel tank controller: debounced 3-probe level, hysteretic fill valve, latched faults.
// Valve/fault are Moore outputs of the registered channel state (one edge after deb changes); no backpressure.
module tank_level_ctrl #(
   parameter int N_CH         = 4,
   parameter int DEB_CYC      = 4,
   parameter int FILL_TIMEOUT = 1000
) (
   input  logic              clk,
   input  logic              reset,
   tank_level_ctrl_if.slave  io
);
   localparam int TW = $clog2(FILL_TIMEOUT + 1);
   localparam int DW = $clog2(DEB_CYC + 1);

   localparam logic [1:0] FC_NONE    = 2'd0;
   localparam logic [1:0] FC_SENSOR  = 2'd1;
   localparam logic [1:0] FC_TIMEOUT = 2'd2;
   localparam logic [1:0] FC_EXT     = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      FAULT = 2'd2
   } state_t;

   logic [N_CH-1:0]   valve_w;
   logic [N_CH-1:0]   fault_w;
   logic [2*N_CH-1:0] level_w;
   logic [2*N_CH-1:0] code_w;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic [2:0]    prb;
      logic [2:0]    smp_q;
      logic [2:0]    deb_q;
      logic [DW-1:0] run_q;
      logic [DW-1:0] run_d;
      logic [TW-1:0] tmr_q;
      logic [TW-1:0] tmr_d;
      logic [1:0]    code_q;
      logic [1:0]    code_d;
      logic [1:0]    lvl;
      logic          deb_ok;
      state_t        st_q;
      state_t        st_d;

      assign prb = io.probe[3*i +: 3];

      // run_d counts consecutive identical samples including the current edge
      always_comb begin
         run_d = DW'(1);
         if (prb == smp_q) begin
            run_d = (run_q == DW'(DEB_CYC)) ? run_q : run_q + 1'b1;
         end
      end

      always_comb begin
         deb_ok = 1'b1;
         lvl    = 2'd0;
         case (deb_q)
            3'b000:  lvl = 2'd0;
            3'b001:  lvl = 2'd1;
            3'b011:  lvl = 2'd2;
            3'b111:  lvl = 2'd3;
            default: deb_ok = 1'b0;
         endcase
      end

      always_comb begin
         st_d   = st_q;
         code_d = code_q;
         tmr_d  = tmr_q;
         case (st_q)
            IDLE: begin
               if (io.ext_fault[i]) begin
                  st_d   = FAULT;
                  code_d = FC_EXT;
               end else if (!deb_ok) begin
                  st_d   = FAULT;
                  code_d = FC_SENSOR;
               end else if (io.en && lvl == 2'd0) begin
                  st_d  = FILL;
                  tmr_d = '0;
               end
            end
            FILL: begin
               tmr_d = (tmr_q == TW'(FILL_TIMEOUT)) ? tmr_q : tmr_q + 1'b1;
               if (io.ext_fault[i]) begin
                  st_d   = FAULT;
                  code_d = FC_EXT;
               end else if (!deb_ok) begin
                  st_d   = FAULT;
                  code_d = FC_SENSOR;
               end else if (lvl == 2'd3 || !io.en) begin
                  st_d = IDLE;
               end else if (tmr_q == TW'(FILL_TIMEOUT - 1)) begin
                  st_d   = FAULT;
                  code_d = FC_TIMEOUT;
               end
            end
            FAULT: begin
               if (io.fault_clr[i] && !io.ext_fault[i] && deb_ok) begin
                  st_d   = IDLE;
                  code_d = FC_NONE;
               end
            end
            default: begin
               st_d   = IDLE;
               code_d = FC_NONE;
            end
         endcase
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            st_q   <= IDLE;
            code_q <= FC_NONE;
            tmr_q  <= '0;
            smp_q  <= 3'b111;
            deb_q  <= 3'b111;
            run_q  <= '0;
         end else begin
            st_q   <= st_d;
            code_q <= code_d;
            tmr_q  <= tmr_d;
            smp_q  <= prb;
            run_q  <= run_d;
            if (run_d == DW'(DEB_CYC)) begin
               deb_q <= prb;
            end
         end
      end

      assign valve_w[i]         = (st_q == FILL);
      assign fault_w[i]         = (st_q == FAULT);
      assign level_w[2*i +: 2]  = lvl;
      assign code_w[2*i +: 2]   = code_q;
   end

   assign io.valve      = valve_w;
   assign io.fault      = fault_w;
   assign io.level      = level_w;
   assign io.fault_code = code_w;
   assign io.any_fault  = |fault_w;
endmodule

// File: tb/tb_tank_level_ctrl.sv
// Bench for tank_level_ctrl: directed scenarios plus random stimulus against a sample-history reference model.
module tb_tank_level_ctrl;
   localparam int N_CH = 4;
   localparam int DEB  = 4;
   localparam int FT   = 32;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   tank_level_ctrl_if #(.N_CH(N_CH)) bus ();

   tank_level_ctrl #(
      .N_CH(N_CH), .DEB_CYC(DEB), .FILL_TIMEOUT(FT)
   ) dut (
      .clk(clk), .reset(reset), .io(bus)
   );

   always #5 clk = ~clk;

   // Reference model: deb accepted when the last DEB samples agree; level = number of ones of a thermometer code
   logic [2:0] m_hist  [N_CH][DEB];
   int         m_nseen [N_CH];
   logic [2:0] m_deb   [N_CH];
   bit         m_fill  [N_CH];
   bit         m_flt   [N_CH];
   int         m_code  [N_CH];
   int         m_fcyc  [N_CH];

   function automatic bit therm_ok(logic [2:0] v);
      return (v == 3'b000) || (v == 3'b001) || (v == 3'b011) || (v == 3'b111);
   endfunction

   task automatic model_reset();
      for (int c = 0; c < N_CH; c++) begin
         m_nseen[c] = 0;
         m_deb[c]   = 3'b111;
         m_fill[c]  = 1'b0;
         m_flt[c]   = 1'b0;
         m_code[c]  = 0;
         m_fcyc[c]  = 0;
         for (int k = 0; k < DEB; k++) m_hist[c][k] = 3'b000;
      end
   endtask

   task automatic model_step();
      for (int c = 0; c < N_CH; c++) begin
         logic [2:0] p;
         bit ok;
         bit same;
         int lv;
         p  = bus.probe[3*c +: 3];
         ok = therm_ok(m_deb[c]);
         lv = ok ? $countones(m_deb[c]) : 0;
         if (m_flt[c]) begin
            if (bus.fault_clr[c] && !bus.ext_fault[c] && ok) begin
               m_flt[c]  = 1'b0;
               m_code[c] = 0;
            end
         end else if (bus.ext_fault[c]) begin
            m_flt[c] = 1'b1; m_code[c] = 3; m_fill[c] = 1'b0;
         end else if (!ok) begin
            m_flt[c] = 1'b1; m_code[c] = 1; m_fill[c] = 1'b0;
         end else if (m_fill[c]) begin
            m_fcyc[c]++;
            if (lv == 3 || !bus.en) begin
               m_fill[c] = 1'b0;
            end else if (m_fcyc[c] == FT) begin
               m_fill[c] = 1'b0; m_flt[c] = 1'b1; m_code[c] = 2;
            end
         end else if (bus.en && lv == 0) begin
            m_fill[c] = 1'b1;
            m_fcyc[c] = 0;
         end
         for (int k = DEB - 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
         m_hist[c][0] = p;
         if (m_nseen[c] < DEB) m_nseen[c]++;
         same = 1'b1;
         for (int k = 0; k < DEB; k++) if (m_hist[c][k] != p) same = 1'b0;
         if (m_nseen[c] >= DEB && same) m_deb[c] = p;
      end
   endtask

   function automatic logic [N_CH-1:0] e_valve();
      logic [N_CH-1:0] v;
      for (int c = 0; c < N_CH; c++) v[c] = m_fill[c];
      return v;
   endfunction

   function automatic logic [N_CH-1:0] e_fault();
      logic [N_CH-1:0] v;
      for (int c = 0; c < N_CH; c++) v[c] = m_flt[c];
      return v;
   endfunction

   function automatic logic [2*N_CH-1:0] e_level();
      logic [2*N_CH-1:0] v;
      for (int c = 0; c < N_CH; c++)
         v[2*c +: 2] = therm_ok(m_deb[c]) ? 2'($countones(m_deb[c])) : 2'd0;
      return v;
   endfunction

   function automatic logic [2*N_CH-1:0] e_code();
      logic [2*N_CH-1:0] v;
      for (int c = 0; c < N_CH; c++) v[2*c +: 2] = 2'(m_code[c]);
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic set_probe(int c, logic [2:0] v);
      bus.probe[3*c +: 3] = v;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks += 5;
      if (bus.valve !== '0) begin errors++; $display("FAIL reset_valve got %h exp 0", bus.valve); end
      if (bus.level !== '1) begin errors++; $display("FAIL reset_level got %h exp ff", bus.level); end
      if (bus.fault !== '0) begin errors++; $display("FAIL reset_fault got %h exp 0", bus.fault); end
      if (bus.fault_code !== '0) begin errors++; $display("FAIL reset_code got %h exp 0", bus.fault_code); end
      if (bus.any_fault !== 1'b0) begin errors++; $display("FAIL reset_any got %b exp 0", bus.any_fault); end
   endtask

   task automatic test_fill_start();
      set_probe(0, 3'b000);
      bus.en = 1'b1;
      for (int e = 0; e < 6; e++) begin
         tick();
         checks++;
         if (bus.valve !== e_valve() || bus.level !== e_level()) begin
            errors++;
            $display("FAIL start_model edge %0d got v=%h l=%h exp v=%h l=%h", e, bus.valve, bus.level, e_valve(), e_level());
         end
         if (e == 2) begin
            checks++;
            if (bus.level[1:0] !== 2'd3) begin errors++; $display("FAIL start_early_level got %0d exp 3", bus.level[1:0]); end
         end
         if (e == 3) begin
            checks += 2;
            if (bus.level[1:0] !== 2'd0) begin errors++; $display("FAIL start_level0 got %0d exp 0", bus.level[1:0]); end
            if (bus.valve[0] !== 1'b0) begin errors++; $display("FAIL start_valve_early got %b exp 0", bus.valve[0]); end
         end
         if (e == 4) begin
            checks += 2;
            if (bus.valve !== 4'b0001) begin errors++; $display("FAIL start_valve got %b exp 0001", bus.valve); end
            if (bus.level[7:2] !== 6'b111111) begin errors++; $display("FAIL start_others_level got %b exp 111111", bus.level[7:2]); end
         end
      end
   endtask

   task automatic test_fill_levels();
      logic [2:0] seq [3];
      bit saw3;
      seq[0] = 3'b001; seq[1] = 3'b011; seq[2] = 3'b111;
      saw3 = 1'b0;
      for (int s = 0; s < 3; s++) begin
         set_probe(0, seq[s]);
         for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (bus.valve !== e_valve()) begin errors++; $display("FAIL levels_model got %b exp %b", bus.valve, e_valve()); end
            if (s < 2) begin
               checks++;
               if (bus.valve[0] !== 1'b1) begin errors++; $display("FAIL levels_hold s=%0d k=%0d got %b exp 1", s, k, bus.valve[0]); end
            end else if (!saw3 && bus.level[1:0] === 2'd3) begin
               saw3 = 1'b1;
               checks++;
               if (bus.valve[0] !== 1'b1) begin errors++; $display("FAIL levels_full_edge got %b exp 1", bus.valve[0]); end
            end else if (saw3) begin
               checks++;
               if (bus.valve[0] !== 1'b0) begin errors++; $display("FAIL levels_close got %b exp 0", bus.valve[0]); end
            end
         end
      end
      checks++;
      if (!saw3) begin errors++; $display("FAIL levels_reach_full got %0d exp 3", bus.level[1:0]); end
      set_probe(0, 3'b011);
      for (int k = 0; k < 10; k++) begin
         tick();
         checks++;
         if (bus.valve[0] !== 1'b0) begin errors++; $display("FAIL levels_no_reopen got %b exp 0", bus.valve[0]); end
      end
   endtask

   task automatic test_glitch();
      for (int k = 0; k < 9; k++) begin
         set_probe(1, (k < 3) ? 3'b000 : 3'b111);
         tick();
         checks++;
         if (bus.level[3:2] !== 2'd3 || bus.valve[1] !== 1'b0) begin
            errors++;
            $display("FAIL glitch k=%0d got l=%0d v=%b exp l=3 v=0", k, bus.level[3:2], bus.valve[1]);
         end
      end
   endtask

   task automatic test_timeout();
      int fk;
      set_probe(2, 3'b000);
      for (int k = 0; k < 12 && bus.valve[2] !== 1'b1; k++) tick();
      checks++;
      if (bus.valve[2] !== 1'b1) begin errors++; $display("FAIL timeout_open got %b exp 1", bus.valve[2]); end
      set_probe(2, 3'b001);
      fk = -1;
      for (int k = 1; k <= FT + 3; k++) begin
         tick();
         if (fk < 0 && bus.fault[2] === 1'b1) fk = k;
         checks++;
         if (bus.fault !== e_fault() || bus.valve !== e_valve()) begin
            errors++;
            $display("FAIL timeout_model k=%0d got f=%b v=%b exp f=%b v=%b", k, bus.fault, bus.valve, e_fault(), e_valve());
         end
      end
      checks += 3;
      if (fk != FT) begin errors++; $display("FAIL timeout_cycle got %0d exp %0d", fk, FT); end
      if (bus.fault_code[5:4] !== 2'd2) begin errors++; $display("FAIL timeout_code got %0d exp 2", bus.fault_code[5:4]); end
      if (bus.valve[2] !== 1'b0) begin errors++; $display("FAIL timeout_valve got %b exp 0", bus.valve[2]); end
      bus.fault_clr[2] = 1'b1;
      tick();
      bus.fault_clr[2] = 1'b0;
      checks += 2;
      if (bus.fault[2] !== 1'b0) begin errors++; $display("FAIL timeout_clear got %b exp 0", bus.fault[2]); end
      if (bus.fault_code[5:4] !== 2'd0) begin errors++; $display("FAIL timeout_clear_code got %0d exp 0", bus.fault_code[5:4]); end
      for (int k = 0; k < 10; k++) begin
         tick();
         checks++;
         if (bus.valve[2] !== 1'b0) begin errors++; $display("FAIL timeout_no_refill got %b exp 0", bus.valve[2]); end
      end
   endtask

   task automatic test_ext_fault();
      set_probe(3, 3'b101);
      for (int k = 0; k < DEB - 1; k++) begin
         tick();
         checks++;
         if (bus.fault[3] !== 1'b0) begin errors++; $display("FAIL ext_pre k=%0d got %b exp 0", k, bus.fault[3]); end
      end
      bus.ext_fault[3] = 1'b1;
      tick();
      checks += 2;
      if (bus.fault[3] !== 1'b1) begin errors++; $display("FAIL ext_fault got %b exp 1", bus.fault[3]); end
      if (bus.fault_code[7:6] !== 2'd3) begin errors++; $display("FAIL ext_code got %0d exp 3", bus.fault_code[7:6]); end
      bus.fault_clr[3] = 1'b1;
      tick();
      bus.fault_clr[3] = 1'b0;
      checks += 2;
      if (bus.fault[3] !== 1'b1) begin errors++; $display("FAIL ext_clr_ignored got %b exp 1", bus.fault[3]); end
      if (bus.fault_code[7:6] !== 2'd3) begin errors++; $display("FAIL ext_code_held got %0d exp 3", bus.fault_code[7:6]); end
      bus.ext_fault[3] = 1'b0;
      set_probe(3, 3'b111);
      for (int k = 0; k < DEB + 1; k++) tick();
      checks++;
      if (bus.fault[3] !== 1'b1) begin errors++; $display("FAIL ext_no_autoclear got %b exp 1", bus.fault[3]); end
      bus.fault_clr[3] = 1'b1;
      tick();
      bus.fault_clr[3] = 1'b0;
      checks += 3;
      if (bus.fault[3] !== 1'b0) begin errors++; $display("FAIL ext_cleared got %b exp 0", bus.fault[3]); end
      if (bus.fault_code[7:6] !== 2'd0) begin errors++; $display("FAIL ext_code_clear got %0d exp 0", bus.fault_code[7:6]); end
      if (bus.any_fault !== 1'b0) begin errors++; $display("FAIL ext_any got %b exp 0", bus.any_fault); end
   endtask

   task automatic test_random();
      int hold [N_CH];
      int nprint;
      nprint = 0;
      for (int c = 0; c < N_CH; c++) hold[c] = 0;
      for (int n = 0; n < 1500; n++) begin
         for (int c = 0; c < N_CH; c++) begin
            if (hold[c] == 0) begin
               logic [2:0] v;
               case ($urandom_range(0, 6))
                  0, 1:    v = 3'b000;
                  2:       v = 3'b001;
                  3:       v = 3'b011;
                  4, 5:    v = 3'b111;
                  default: v = 3'($urandom_range(0, 7));
               endcase
               set_probe(c, v);
               hold[c] = $urandom_range(1, 10);
            end
            hold[c]--;
            bus.ext_fault[c] = ($urandom_range(0, 199) == 0);
            bus.fault_clr[c] = ($urandom_range(0, 7) == 0);
         end
         bus.en = ($urandom_range(0, 19) != 0);
         tick();
         checks++;
         if (bus.valve !== e_valve() || bus.level !== e_level() || bus.fault !== e_fault() ||
             bus.fault_code !== e_code() || bus.any_fault !== (|e_fault())) begin
            errors++;
            if (nprint < 10) begin
               nprint++;
               $display("FAIL random n=%0d got v=%h l=%h f=%h c=%h a=%b exp v=%h l=%h f=%h c=%h", n,
                        bus.valve, bus.level, bus.fault, bus.fault_code, bus.any_fault,
                        e_valve(), e_level(), e_fault(), e_code());
            end
         end
      end
      bus.ext_fault = '0;
      bus.fault_clr = '0;
   endtask

   task automatic test_async_reset();
      bus.probe = '1;
      do_reset();
      set_probe(0, 3'b000);
      bus.en = 1'b1;
      for (int k = 0; k < 6; k++) tick();
      checks++;
      if (bus.valve !== 4'b0001) begin errors++; $display("FAIL areset_pre_valve got %b exp 0001", bus.valve); end
      #3 reset = 1'b1;
      model_reset();
      #1;
      checks += 3;
      if (bus.valve !== '0) begin errors++; $display("FAIL areset_valve got %b exp 0", bus.valve); end
      if (bus.level !== '1) begin errors++; $display("FAIL areset_level got %h exp ff", bus.level); end
      if (bus.fault !== '0) begin errors++; $display("FAIL areset_fault got %b exp 0", bus.fault); end
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      bus.en = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         checks++;
         if (bus.valve !== '0 || bus.valve !== e_valve()) begin
            errors++;
            $display("FAIL areset_en_off k=%0d got %b exp 0", k, bus.valve);
         end
      end
      checks++;
      if (bus.level[1:0] !== 2'd0) begin errors++; $display("FAIL areset_level0 got %0d exp 0", bus.level[1:0]); end
   endtask

   initial begin
      bus.en        = 1'b0;
      bus.probe     = '1;
      bus.ext_fault = '0;
      bus.fault_clr = '0;
      model_reset();
      test_reset();
      test_fill_start();
      test_fill_levels();
      test_glitch();
      test_timeout();
      test_ext_fault();
      test_random();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
